// File: rtl/stream_upsizer_packer.sv
// Packs RATIO narrow beats into one wide word with per-lane keep and packet last.
// One-cycle registered output; input stalls only while a full output word is not drained.
module stream_upsizer_packer #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [IN_WIDTH-1:0]       bwd_data_i,
  input  logic                      bwd_last_i,
  input  logic                      bwd_valid_i,
  output logic                      bwd_ready_o,
  output logic [IN_WIDTH*RATIO-1:0] fwd_data_o,
  output logic [RATIO-1:0]          fwd_keep_o,
  output logic                      fwd_last_o,
  output logic                      fwd_valid_o,
  input  logic                      fwd_ready_i
);

  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int CW        = $clog2(RATIO);

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] acc_data_q, acc_data_d;
  logic [RATIO-1:0]     acc_keep_q, acc_keep_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [RATIO-1:0]     out_keep_q, out_keep_d;
  logic                 out_last_q, out_last_d;
  logic                 out_valid_q, out_valid_d;

  logic                 in_hs, out_hs, complete;
  logic [OUT_WIDTH-1:0] merged_data;
  logic [RATIO-1:0]     lane_onehot;

  assign bwd_ready_o = rst_n & (~out_valid_q | fwd_ready_i);
  assign in_hs       = bwd_valid_i & bwd_ready_o;
  assign out_hs      = out_valid_q & fwd_ready_i;
  assign complete    = in_hs & ((cnt_q == CW'(RATIO - 1)) | bwd_last_i);

  // Current beat dropped into lane cnt of the accumulator.
  always_comb begin
    merged_data = acc_data_q;
    lane_onehot = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (cnt_q == CW'(k)) begin
        merged_data[k*IN_WIDTH +: IN_WIDTH] = bwd_data_i;
        lane_onehot[k]                      = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    acc_data_d  = acc_data_q;
    acc_keep_d  = acc_keep_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    if (complete) begin
      out_data_d  = merged_data;
      out_keep_d  = acc_keep_q | lane_onehot;
      out_last_d  = bwd_last_i;
      out_valid_d = 1'b1;
      acc_data_d  = '0;
      acc_keep_d  = '0;
      cnt_d       = '0;
    end else begin
      if (in_hs) begin
        acc_data_d = merged_data;
        acc_keep_d = acc_keep_q | lane_onehot;
        cnt_d      = cnt_q + CW'(1);
      end
      if (out_hs) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      acc_data_q  <= '0;
      acc_keep_q  <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_data_q  <= acc_data_d;
      acc_keep_q  <= acc_keep_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign fwd_data_o  = out_data_q;
  assign fwd_keep_o  = out_keep_q;
  assign fwd_last_o  = out_last_q;
  assign fwd_valid_o = out_valid_q;

endmodule

// File: tb/tb_stream_upsizer_packer.sv
// Scoreboard bench for stream_upsizer_packer at IN_WIDTH=8, RATIO=4.
module tb_stream_upsizer_packer;

  localparam int IW = 8;
  localparam int R  = 4;
  localparam int OW = IW * R;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [IW-1:0] bwd_data_i;
  logic          bwd_last_i;
  logic          bwd_valid_i;
  logic          bwd_ready_o;
  logic [OW-1:0] fwd_data_o;
  logic [R-1:0]  fwd_keep_o;
  logic          fwd_last_o;
  logic          fwd_valid_o;
  logic          fwd_ready_i;

  int vectors    = 0;
  int miscompares = 0;
  int words_seen = 0;
  logic [OW+R:0] exp_q[$];

  logic [OW-1:0] m_data;
  logic [R-1:0]  m_keep;
  int            m_cnt;

  always #5 clk = ~clk;

  stream_upsizer_packer #(.IN_WIDTH(IW), .RATIO(R)) dut (
    .clk(clk), .rst_n(rst_n),
    .bwd_data_i(bwd_data_i), .bwd_last_i(bwd_last_i),
    .bwd_valid_i(bwd_valid_i), .bwd_ready_o(bwd_ready_o),
    .fwd_data_o(fwd_data_o), .fwd_keep_o(fwd_keep_o),
    .fwd_last_o(fwd_last_o), .fwd_valid_o(fwd_valid_o),
    .fwd_ready_i(fwd_ready_i)
  );

  // Output monitor: a word shown with valid & ready at negedge is taken at the next posedge.
  always @(negedge clk) begin
    if (rst_n && fwd_valid_o && fwd_ready_i) begin
      logic [OW+R:0] exp_w;
      vectors++;
      words_seen++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard unexpected word: got last=%b keep=%h data=%h, want none",
                 fwd_last_o, fwd_keep_o, fwd_data_o);
      end else begin
        exp_w = exp_q.pop_front();
        if ({fwd_last_o, fwd_keep_o, fwd_data_o} !== exp_w) begin
          miscompares++;
          $display("FAIL scoreboard word: got last=%b keep=%h data=%h, want last=%b keep=%h data=%h",
                   fwd_last_o, fwd_keep_o, fwd_data_o, exp_w[OW+R], exp_w[OW +: R], exp_w[OW-1:0]);
        end
      end
    end
  end

  task automatic model_clear();
    m_data = '0;
    m_keep = '0;
    m_cnt  = 0;
  endtask

  task automatic idle(input int n);
    bwd_valid_i = 1'b0;
    bwd_last_i  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one beat until accepted; updates the reference packer model on acceptance.
  task automatic send_beat(input logic [IW-1:0] d, input logic l);
    int   n;
    logic acc;
    bwd_data_i  = d;
    bwd_last_i  = l;
    bwd_valid_i = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bwd_ready_o;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL send_beat timeout: got bwd_ready_o=0 for 50 cycles, want 1");
    end else begin
      m_data[m_cnt*IW +: IW] = d;
      m_keep[m_cnt] = 1'b1;
      if (m_cnt == R - 1 || l) begin
        exp_q.push_back({l, m_keep, m_data});
        model_clear();
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic check_out(input string name, input logic [OW-1:0] d, input logic [R-1:0] k,
                           input logic l);
    vectors++;
    if (fwd_valid_o !== 1'b1 || fwd_data_o !== d || fwd_keep_o !== k || fwd_last_o !== l) begin
      miscompares++;
      $display("FAIL %s: got v=%b data=%h keep=%h last=%b, want v=1 data=%h keep=%h last=%b",
               name, fwd_valid_o, fwd_data_o, fwd_keep_o, fwd_last_o, d, k, l);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (bwd_ready_o !== 1'b0 || fwd_valid_o !== 1'b0 || fwd_keep_o !== 4'h0 ||
        fwd_data_o !== 32'h0 || fwd_last_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got rdy=%b v=%b keep=%h data=%h last=%b, want all 0",
               bwd_ready_o, fwd_valid_o, fwd_keep_o, fwd_data_o, fwd_last_o);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    vectors++;
    if (bwd_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: got bwd_ready_o=%b, want 1", bwd_ready_o);
    end
  endtask

  task automatic test_full_word();
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    send_beat(8'h33, 1'b0);
    send_beat(8'h44, 1'b1);
    check_out("full_word", 32'h44332211, 4'hF, 1'b1);
    idle(2);
  endtask

  task automatic test_short_packet();
    send_beat(8'hAA, 1'b0);
    send_beat(8'hBB, 1'b1);
    check_out("short_packet", 32'h0000BBAA, 4'h3, 1'b1);
    idle(1);
    send_beat(8'h5C, 1'b1);
    check_out("lane0_last", 32'h0000005C, 4'h1, 1'b1);
    idle(2);
  endtask

  task automatic test_backpressure();
    fwd_ready_i = 1'b0;
    send_beat(8'h01, 1'b0);
    send_beat(8'h02, 1'b0);
    send_beat(8'h03, 1'b0);
    send_beat(8'h04, 1'b1);
    idle(0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (bwd_ready_o !== 1'b0 || fwd_valid_o !== 1'b1 || fwd_data_o !== 32'h04030201 ||
          fwd_keep_o !== 4'hF || fwd_last_o !== 1'b1) begin
        miscompares++;
        $display("FAIL backpressure_hold[%0d]: got rdy=%b v=%b data=%h keep=%h last=%b, want rdy=0 v=1 data=04030201 keep=f last=1",
                 i, bwd_ready_o, fwd_valid_o, fwd_data_o, fwd_keep_o, fwd_last_o);
      end
      @(posedge clk);
      #1;
    end
    fwd_ready_i = 1'b1;
    #1;
    vectors++;
    if (bwd_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL backpressure_release: got bwd_ready_o=%b, want 1", bwd_ready_o);
    end
    idle(2);
  endtask

  task automatic test_streaming();
    int start_words;
    start_words = words_seen;
    for (int i = 0; i < 16; i++) begin
      send_beat(8'($urandom_range(0, 255)), (i % 4) == 3);
    end
    idle(3);
    vectors++;
    if (words_seen - start_words != 4) begin
      miscompares++;
      $display("FAIL streaming_words: got %0d words, want 4", words_seen - start_words);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      send_beat(8'(8'hC0 + i), 1'b1);
      vectors++;
      if (fwd_valid_o !== 1'b1 || fwd_data_o !== {24'h0, 8'(8'hC0 + i)}) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got v=%b data=%h, want v=1 data=%h",
                 i, fwd_valid_o, fwd_data_o, {24'h0, 8'(8'hC0 + i)});
      end
    end
    idle(2);
  endtask

  task automatic test_reset_mid_word();
    send_beat(8'h10, 1'b0);
    send_beat(8'h20, 1'b0);
    idle(0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    send_beat(8'h30, 1'b0);
    send_beat(8'h40, 1'b0);
    send_beat(8'h50, 1'b0);
    send_beat(8'h60, 1'b1);
    check_out("reset_mid_word", 32'h60504030, 4'hF, 1'b1);
    idle(2);
  endtask

  initial begin
    rst_n       = 1'b0;
    bwd_data_i  = '0;
    bwd_last_i  = 1'b0;
    bwd_valid_i = 1'b0;
    fwd_ready_i = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    test_reset();
    test_full_word();
    test_short_packet();
    test_backpressure();
    test_streaming();
    test_back_to_back();
    test_reset_mid_word();
    idle(2);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d words still expected, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
